// File: rtl/alu_seq.sv
// alu_seq: clocked, handshaked ALU. ADD/SUB/AND/OR/XOR/SLL/SRL complete in
// one cycle. MUL is an iterative shift-add, one multiplier bit per cycle.
// Result and flags are held in DONE until the consumer takes them.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    operand handshake (in_ready only in IDLE)
//   op, a, b             operation code and operands (b[SHAMT_W-1:0] = shift)
//   out_valid/out_ready  result handshake (out_valid only in DONE)
//   r                    result
//   nflag/oflag/zflag/cflag  negative, overflow, zero, carry/borrow
module alu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] r,
    output logic                  nflag,
    output logic                  oflag,
    output logic                  zflag,
    output logic                  cflag
);

    localparam int W = DATA_WIDTH;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [W-1:0]       r_res;
    logic               r_o, r_c, r_z;
    logic [2*W-1:0]     r_acc;
    logic [W-1:0]       r_mcand;
    logic [SHAMT_W-1:0] r_cnt;

    logic               w_accept, w_mul_last;
    logic [SHAMT_W-1:0] w_shamt;
    logic [W:0]         w_add, w_sub, w_sll, w_srl, w_hi_sum;
    logic [2*W-1:0]     w_acc_nxt;
    logic [W-1:0]       w_res;
    logic               w_o, w_c;

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign w_accept   = in_valid && in_ready;
    // W is a power of two, so the counter's last value is all ones.
    assign w_mul_last = (r_state == BUSY) && (r_cnt == SHAMT_W'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (op == OP_MUL) ? BUSY : DONE;
            BUSY:    if (w_mul_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // One extra bit above the result catches carry/borrow and the last bit
    // shifted out: SLL pushes it into bit W, SRL into bit 0 of {a,0}.
    assign w_shamt = b[SHAMT_W-1:0];
    assign w_add   = {1'b0, a} + {1'b0, b};
    assign w_sub   = {1'b0, a} - {1'b0, b};
    assign w_sll   = {1'b0, a} << w_shamt;
    assign w_srl   = {a, 1'b0} >> w_shamt;

    always_comb begin
        w_res = '0;
        w_o   = 1'b0;
        w_c   = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_add[W-1:0];
                w_c   = w_add[W];
                w_o   = (a[W-1] == b[W-1]) && (w_add[W-1] != a[W-1]);
            end
            OP_SUB: begin
                w_res = w_sub[W-1:0];
                w_c   = w_sub[W];
                w_o   = (a[W-1] != b[W-1]) && (w_sub[W-1] != a[W-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_SLL: begin
                w_res = w_sll[W-1:0];
                w_c   = w_sll[W];
            end
            OP_SRL: begin
                w_res = w_srl[W:1];
                w_c   = w_srl[0];
            end
            default: ;
        endcase
    end

    // Shift-add step: the low half holds the remaining multiplier bits, the
    // high half accumulates; the sum's carry shifts down into the high half.
    assign w_hi_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt = {w_hi_sum, r_acc[W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res   <= '0;
            r_o     <= 1'b0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            if (op == OP_MUL) begin
                r_acc   <= {{W{1'b0}}, a};
                r_mcand <= b;
                r_cnt   <= '0;
            end else begin
                r_res <= w_res;
                r_o   <= w_o;
                r_c   <= w_c;
                r_z   <= (w_res == '0);
            end
        end else if (r_state == BUSY) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_mul_last) begin
                r_res <= w_acc_nxt[W-1:0];
                r_o   <= |w_acc_nxt[2*W-1:W];
                r_c   <= 1'b0;
                r_z   <= (w_acc_nxt[W-1:0] == '0);
            end
        end
    end

    assign r     = r_res;
    assign nflag = r_res[W-1];
    assign oflag = r_o;
    assign zflag = r_z;
    assign cflag = r_c;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r;
    logic        nflag, oflag, zflag, cflag;

    int n_chk  = 0;
    int n_pass = 0;

    alu_seq #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .nflag(nflag), .oflag(oflag), .zflag(zflag), .cflag(cflag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Reference: plain wide/signed arithmetic, returns {r, N, O, Z, C}.
    function automatic logic [35:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ux, uy, w;
        longint      sx, sy, ss;
        longint      smax, smin;
        logic [31:0] res;
        logic        ov, cy;
        int          s;
        ux = x; uy = y;
        sx = $signed(x); sy = $signed(y);
        smax = 2147483647; smin = -smax - 1;
        s = int'(y[4:0]);
        res = '0; ov = 1'b0; cy = 1'b0; w = '0; ss = 0;
        case (o)
            3'd0: begin
                w = ux + uy; res = w[31:0]; cy = (w > 64'hFFFF_FFFF);
                ss = sx + sy; ov = (ss > smax) || (ss < smin);
            end
            3'd1: begin
                res = x - y; cy = (x < y);
                ss = sx - sy; ov = (ss > smax) || (ss < smin);
            end
            3'd2: res = x & y;
            3'd3: res = x | y;
            3'd4: res = x ^ y;
            3'd5: begin
                w = ux << s; res = w[31:0];
                if (s != 0) cy = w[32];
            end
            3'd6: begin
                res = x >> s;
                if (s != 0) cy = x[s-1];
            end
            default: begin
                w = ux * uy; res = w[31:0]; ov = (w[63:32] != 0);
            end
        endcase
        return {res, res[31], ov, (res == 32'd0), cy};
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input int stall);
        logic [35:0] e;
        logic [31:0] held;
        logic        bad;
        int          n, lat;
        e = model(o, av, bv);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = av; b = bv; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(n < 200), 64'd1);
        if (n >= 200) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble inputs after the accept edge: they must not matter now.
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        lat = 1; bad = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (in_ready) bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), (o == 3'b111) ? 64'd33 : 64'd1);
        chk("busy_ready", 64'(bad), 64'd0);
        chk("r", 64'(r), 64'(e[35:4]));
        chk("flags_nozc", 64'({nflag, oflag, zflag, cflag}), 64'(e[3:0]));
        held = r; bad = 1'b0;
        for (int i = 0; i < stall; i++) begin
            // A competing request during the stall must be ignored.
            in_valid = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
            @(negedge clk);
            if (!out_valid || in_ready || r !== held) bad = 1'b1;
        end
        if (stall > 0) chk("stall_hold", 64'(bad), 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("release", 64'({out_valid, in_ready}), 64'b01);
        out_ready = 1'b0;
    endtask

    initial begin
        logic        bad;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        #3;
        chk("reset_state", 64'({out_valid, in_ready, r, nflag, oflag, zflag, cflag}), {28'd0, 2'b01, 32'd0, 4'd0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(3'b001, 32'h8000_0000, 32'h0000_0001, 0);
        run_op(3'b001, 32'h0000_0001, 32'h0000_0002, 0);
        run_op(3'b111, 32'h0001_0000, 32'h0001_0000, 0);
        run_op(3'b111, 32'h0000_FFFF, 32'h0000_0003, 0);
        run_op(3'b010, 32'hF0F0_F0F0, 32'hCFCF_CFCF, 5);
        run_op(3'b011, 32'h1234_0000, 32'h0000_5678, 0);
        run_op(3'b101, 32'h8000_0001, 32'hFFFF_FFE1, 0);
        run_op(3'b110, 32'h0000_0001, 32'h0000_0000, 0);
        run_op(3'b100, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 0);
        run_op(3'b110, 32'h8000_0001, 32'h0000_001F, 1);
        run_op(3'b101, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        for (int k = 0; k < 30; k++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 33)) : $urandom;
            run_op(ro, ra, rb, $urandom_range(0, 2));
        end

        // Reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1; op = 3'b111; a = $urandom; b = $urandom;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 64'({out_valid, in_ready, r, nflag, oflag, zflag, cflag}), {28'd0, 2'b01, 32'd0, 4'd0});
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        chk("no_stale_mul", 64'(bad), 64'd0);
        run_op(3'b000, 32'd1, 32'd2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the team's combinational 4-op ALU.
- Codes 000–011 keep the legacy operations (ADD, SUB, AND, OR) with the same N/O/Z flags.
- Adds XOR, logical shifts, an iterative unsigned multiply, a carry flag, and valid/ready handshakes on both sides.
- Sits between an operand-issue stage and a result consumer that may apply backpressure.

Parameters:
- DATA_WIDTH, 32, operand and result width; must be a power of two and ≥ 4.
- SHAMT_W, $clog2(DATA_WIDTH), width of the shift-amount field taken from B.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  block accepts a new operation this cycle.
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
- a  input  DATA_WIDTH  operand A.
- b  input  DATA_WIDTH  operand B; B[SHAMT_W-1:0] is the shift amount.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result.
- r  output  DATA_WIDTH  result.
- nflag  output  1  r[DATA_WIDTH-1].
- oflag  output  1  overflow (definition per op below).
- zflag  output  1  r == 0.
- cflag  output  1  carry or borrow (per op below).

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values: state IDLE; in_ready=1; out_valid=0; r=0; nflag=oflag=zflag=cflag=0; multiply counter and accumulator cleared.
- Reset asserted mid-operation (BUSY or DONE) abandons the operation immediately. No result is ever presented for it.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). It is a pure state decode with no combinational path from out_ready.
- Accept: in_valid && in_ready at a rising edge. a, b and op are captured at that edge. Later changes to the inputs have no effect.
- IDLE, accepting a non-MUL op:
  - r and flags are registered at the accept edge; state goes to DONE.
  - out_valid is high in the cycle after the accept (latency 1).
- IDLE, accepting MUL:
  - State goes to BUSY; counter=0; accumulator = {DATA_WIDTH zeros, a}; multiplicand = b.
  - Shift-add: one multiplier bit per BUSY cycle.
  - After the DATA_WIDTH-th BUSY edge, the result is registered and state goes to DONE.
  - out_valid is first high DATA_WIDTH+1 cycles after the accept edge.
- DONE:
  - out_valid=1. r and flags are held stable until out_ready=1 at a rising edge.
  - At that edge state returns to IDLE and out_valid drops.
  - A new op can be accepted no earlier than the following edge. Minimum spacing is 2 cycles per non-MUL op.
- Inputs ignored outside IDLE: in_valid outside IDLE is ignored, with no queuing. The source must hold its request until in_ready.
- out_ready outside DONE has no effect.
- Arithmetic (all at DATA_WIDTH; results truncate and wrap modulo 2^DATA_WIDTH):
  - ADD: r=a+b. cflag = carry out of the MSB. oflag = signed overflow (operands share a sign and r's sign differs).
  - SUB: r=a-b. cflag = borrow (1 when a<b unsigned). oflag = signed overflow (operand signs differ and r's sign differs from a's).
  - AND, OR, XOR: bitwise. oflag=0, cflag=0.
  - SLL, SRL: logical shift by b[SHAMT_W-1:0]; upper bits of b are ignored. cflag = last bit shifted out (0 if the amount is 0). oflag=0.
  - MUL: unsigned. r = low DATA_WIDTH bits of the product. oflag=1 if the high half is nonzero. cflag=0.
- Flags for every op: nflag=r[MSB], zflag=(r==0).

Test Plan:
- Reset, then ADD a=FFFFFFFF b=00000001, out_ready=1 → one cycle after accept: r=00000000, Z=1, C=1, O=0, N=0; back in IDLE the next cycle.
- SUB a=80000000 b=00000001 → r=7FFFFFFF, O=1, C=0, N=0. Then SUB a=00000001 b=00000002 → r=FFFFFFFF, C=1, N=1, O=0.
- MUL a=00010000 b=00010000 → in_ready=0 for the whole BUSY period; out_valid first high exactly 33 cycles after accept; r=00000000, O=1, Z=1. Then MUL a=0000FFFF b=00000003 → r=0002FFFD, O=0.
- Backpressure: AND a=F0F0F0F0 b=CFCFCFCF with out_ready=0 for 5 cycles → r=C0C0C0C0 held stable, out_valid=1, in_ready=0. A second in_valid during the stall is ignored. Raising out_ready → IDLE, then the second op is accepted.
- Shifts and XOR:
  - SLL a=80000001 b=FFFFFFE1 (amount 1) → r=00000002, C=1.
  - SRL a=00000001 b=00000000 → r=00000001, C=0.
  - XOR a=AAAAAAAA b=AAAAAAAA → r=0, Z=1.
- Reset mid-MUL: assert rst_n=0 ten cycles into BUSY → out_valid=0, in_ready=1 and all outputs 0 immediately (asynchronously). After release, ADD a=1 b=2 returns r=3 with no stale MUL result ever presented.
